// File: rtl/bcd_freq_synth.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_freq_synth                                               |
// | Description : BCD frequency setpoint editor with a sequential BCD-to-binary |
// |               converter and divider that drives a glitch-free square wave. |
// |               Define BCD_FREQ_SYNTH_CURSOR_EN to enable the digit cursor.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_freq_synth #(
    parameter int          DIGITS = 6,
    parameter int unsigned CLK_HZ = 50_000_000,
    localparam int         CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    input  logic                cur_left,
    input  logic                cur_right,
    output logic [4*DIGITS-1:0] digits,
    output logic [CW-1:0]       cursor,
    output logic [31:0]         freq_bin,
    output logic                busy,
    output logic                square
);

    localparam logic [1:0]          c_st_idle    = 2'd0;
    localparam logic [1:0]          c_st_conv    = 2'd1;
    localparam logic [1:0]          c_st_div     = 2'd2;
    localparam logic [1:0]          c_st_load    = 2'd3;
    localparam logic [4*DIGITS-1:0] c_all_nines  = {DIGITS{4'h9}};
    localparam logic [31:0]         c_dividend   = 32'(CLK_HZ / 2);
    localparam logic [4:0]          c_last_digit = 5'(DIGITS - 1);
    localparam logic [CW-1:0]       c_cur_max    = CW'(DIGITS - 1);

    logic [4*DIGITS-1:0] r_digits;
    logic [CW-1:0]       w_cursor;
    logic [1:0]          r_state;
    logic [4:0]          r_cnt;
    logic [31:0]         r_acc;
    logic [31:0]         r_rem;
    logic [31:0]         r_q;
    logic [31:0]         r_freq;
    logic [31:0]         r_pend;
    logic [31:0]         r_half;
    logic [31:0]         r_gen_cnt;
    logic                r_square;

    logic [4*DIGITS-1:0] w_inc_digits;
    logic [4*DIGITS-1:0] w_dec_digits;
    logic [4*DIGITS-1:0] w_next_digits;
    logic                w_carry;
    logic                w_borrow;
    logic [4:0]          w_sum;
    logic [4:0]          w_diff;
    logic                w_change;
    logic [3:0]          w_conv_digit;
    logic [31:0]         w_acc_next;
    logic [32:0]         w_rem_sh;
    logic                w_q_bit;
    logic [31:0]         w_rem_next;

    // Ripple 10^cursor through the digits; a final carry/borrow means the
    // result left the representable range, so saturate.
    always_comb begin
        w_inc_digits = r_digits;
        w_dec_digits = r_digits;
        w_carry      = 1'b0;
        w_borrow     = 1'b0;
        w_sum        = '0;
        w_diff       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_sum = {1'b0, r_digits[4*i +: 4]} + {4'd0, w_carry}
                  + ((CW'(i) == w_cursor) ? 5'd1 : 5'd0);
            w_carry = (w_sum > 5'd9);
            w_inc_digits[4*i +: 4] = w_carry ? 4'(w_sum - 5'd10) : w_sum[3:0];
            w_diff = {1'b0, r_digits[4*i +: 4]} - {4'd0, w_borrow}
                   - ((CW'(i) == w_cursor) ? 5'd1 : 5'd0);
            w_borrow = w_diff[4];
            w_dec_digits[4*i +: 4] = w_borrow ? 4'(w_diff + 5'd10) : w_diff[3:0];
        end
        if (w_carry)  w_inc_digits = c_all_nines;
        if (w_borrow) w_dec_digits = '0;
    end

    assign w_next_digits = inc ? w_inc_digits : w_dec_digits;
    assign w_change      = (inc ^ dec) && (w_next_digits != r_digits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_digits <= '0;
        else if (w_change) r_digits <= w_next_digits;
    end

`ifdef BCD_FREQ_SYNTH_CURSOR_EN
    logic [CW-1:0] r_cursor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cursor <= '0;
        else if (cur_left && !cur_right && r_cursor != c_cur_max)
            r_cursor <= r_cursor + 1'b1;
        else if (cur_right && !cur_left && r_cursor != '0)
            r_cursor <= r_cursor - 1'b1;
    end

    assign w_cursor = r_cursor;
`else
    logic w_unused_cursor;

    assign w_unused_cursor = cur_left | cur_right;
    assign w_cursor        = '0;
`endif

    always_comb begin
        w_conv_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (5'(DIGITS - 1 - i) == r_cnt) w_conv_digit = r_digits[4*i +: 4];
        end
    end

    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {28'd0, w_conv_digit};
    assign w_rem_sh   = {r_rem, c_dividend[5'd31 - r_cnt]};
    assign w_q_bit    = (w_rem_sh >= {1'b0, r_acc});
    assign w_rem_next = w_q_bit ? 32'(w_rem_sh - {1'b0, r_acc}) : w_rem_sh[31:0];

    // Any new setpoint pre-empts whatever stage is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_freq  <= '0;
            r_pend  <= '0;
        end else if (w_change) begin
            r_state <= c_st_conv;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                c_st_conv: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == c_last_digit) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_q     <= '0;
                        r_state <= (w_acc_next == '0) ? c_st_load : c_st_div;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_st_div: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[30:0], w_q_bit};
                    if (r_cnt == 5'd31) r_state <= c_st_load;
                    else                r_cnt   <= r_cnt + 5'd1;
                end
                c_st_load: begin
                    r_freq  <= r_acc;
                    r_pend  <= (r_acc == '0) ? '0 : ((r_q == '0) ? 32'd1 : r_q);
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // New half-periods are only adopted at a toggle or from idle, so no runts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half    <= '0;
            r_gen_cnt <= '0;
            r_square  <= 1'b0;
        end else if (r_half == '0) begin
            r_half    <= r_pend;
            r_gen_cnt <= '0;
            r_square  <= 1'b0;
        end else if (r_gen_cnt == r_half - 32'd1) begin
            r_gen_cnt <= '0;
            r_half    <= r_pend;
            r_square  <= (r_pend == '0) ? 1'b0 : ~r_square;
        end else begin
            r_gen_cnt <= r_gen_cnt + 32'd1;
        end
    end

    assign digits   = r_digits;
    assign cursor   = w_cursor;
    assign freq_bin = r_freq;
    assign busy     = (r_state != c_st_idle);
    assign square   = r_square;

endmodule
`default_nettype wire

// File: doc/bcd_freq_synth.md
# bcd_freq_synth

Parametrised frequency-setpoint and square-wave generator. It holds a DIGITS-wide BCD setpoint edited by one-cycle up/down/cursor pulses from the key debouncers. It converts the setpoint to binary and computes a half-period with a sequential divider, then drives a glitch-free square wave. The BCD digits feed the existing seven-segment decoder/scan path, and the cursor output drives the digit-blink logic.

## Interface
- DIGITS, 6, number of BCD setpoint digits; legal range 1..9.
- CLK_HZ, 50_000_000, input clock frequency in Hz; must be ≥ 2 and < 2^32.
- CW, $clog2(DIGITS) (min 1), cursor width; derived, not overridden.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inc  in  1  one-cycle pulse: add 10^cursor to setpoint.
- dec  in  1  one-cycle pulse: subtract 10^cursor from setpoint.
- cur_left  in  1  one-cycle pulse: cursor toward MSD.
- cur_right  in  1  one-cycle pulse: cursor toward LSD.
- digits  out  4*DIGITS  BCD setpoint, digit 0 in [3:0].
- cursor  out  CW  selected digit index, 0 = LSD.
- freq_bin  out  32  binary setpoint, updated when a conversion completes.
- busy  out  1  conversion/division in progress.
- square  out  1  generated square wave.

## Operation
- Editing, with inc XOR dec on a cycle:
  - inc adds 10^cursor with BCD carry ripple. If the result exceeds all-9s, digits saturate at all-9s.
  - dec subtracts 10^cursor with BCD borrow. If the result is below 0, digits clamp to all-0s.
  - inc and dec on the same cycle: both ignored.
- Cursor:
  - cur_left increments cursor and saturates at DIGITS-1.
  - cur_right decrements cursor and saturates at 0.
  - Both on the same cycle: ignored.
  - Cursor pulses are independent of inc/dec. An edit on the same cycle as a cursor move uses the old cursor.
- Any change to digits starts a conversion. An edit pulse that leaves digits unchanged (saturated) starts nothing.
- Conversion runs through three states after IDLE:
  - CONV: runs DIGITS cycles, MSD first, acc = acc*10 + digit.
  - DIV: runs 32 cycles of restoring division, q = (CLK_HZ/2) / acc, with the dividend a 32-bit constant. Skipped if acc = 0.
  - LOAD: runs 1 cycle. freq_bin <= acc. pend_half <= (acc = 0) ? 0 : max(q, 1). Returns to IDLE.
- A digits change while busy aborts the current run and restarts at CONV on the next cycle. freq_bin and pend_half keep their old values until a LOAD.
- Generator:
  - A 32-bit counter counts 0..half-1. At half-1 it toggles square and reloads to 0.
  - half is latched from pend_half only at a toggle boundary or while the generator is idle.
  - If half = 0, the generator is idle: square is held at 0 and the counter is held at 0.
  - Leaving idle, the generator latches half and starts counting from 0 with square = 0.
- Reset mid-operation: all state returns to reset values immediately, and any in-flight conversion is discarded.

## Timing
- Reset values:
  - digits = 0, cursor = 0, freq_bin = 0, busy = 0, square = 0.
  - half = 0 and pend_half = 0. State is IDLE.
- Edit pulse sampled at edge k:
  - digits are updated and busy rises at edge k.
  - busy falls at edge k + DIGITS + 33 (k + DIGITS + 1 if the value is 0).
  - freq_bin is valid from that same edge.
- Output period is 2*half clock cycles with exactly 50% duty, giving frequency CLK_HZ/(2*half).
- A new half takes effect at the first toggle after LOAD. Half-periods already in progress complete unchanged, so there are no runt pulses.
- Setpoint > CLK_HZ/2 gives q = 0, forced to half = 1, so square toggles every cycle.

## Configuration
- BCD_FREQ_SYNTH_CURSOR_EN defined: cursor logic as above; cur_left/cur_right are active.
- Not defined: cursor is tied to 0 and cur_left/cur_right are ignored, so inc/dec always act on digit 0. digits, conversion and generator behaviour are unchanged.

## Test plan
- DIGITS=6, CLK_HZ=1000. Stimulus: reset, then 1 inc with cursor moved to 2 (macro on). Response: digits=000100. busy is high for 39 cycles. Then freq_bin=100 and the square period is 10 cycles (5 high / 5 low).
- Stimulus: setpoint 000009 at cursor 0, then inc. Response: digits=000010 (carry). Then dec twice: digits=000008.
- Stimulus: setpoint 000000, then dec. Response: digits stay 000000, busy stays 0, square stays 0. Stimulus: at all-9s, inc at cursor 5. Response: digits stay 999999.
- CLK_HZ=1000. Stimulus: set 600. Response: half forced to 1, square period 2 cycles. Stimulus: set 1. Response: half=500, period 1000 cycles.
- Stimulus: edit during DIV (edge k+20), then a second edit. Response: the first result is never loaded. busy falls DIGITS+33 cycles after the second edit. freq_bin equals the second value.
- Stimulus: change frequency mid-half-period from 100 to 50. Response: the current half (5 cycles) completes, and the next half is 10 cycles. Stimulus: assert rst_n low mid-DIV. Response: all outputs return to reset values.
